// File: rtl/cpu_checker_fsm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cpu_checker_fsm_pkg                                         |
// | Brief    : States, format codes and ASCII constants for the checker.   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package cpu_checker_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_TIME     = 4'd1,
        S_AT_SEEN  = 4'd2,
        S_PC       = 4'd3,
        S_COLON_SP = 4'd4,
        S_REG      = 4'd5,
        S_MEM      = 4'd6,
        S_SP_PRE   = 4'd7,
        S_LT       = 4'd8,
        S_EQ_SP    = 4'd9,
        S_DATA     = 4'd10,
        S_SP_POST  = 4'd11,
        S_DONE_REG = 4'd12,
        S_DONE_MEM = 4'd13
    } state_t;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam logic [7:0] C_CARET  = 8'h5E;
    localparam logic [7:0] C_AT     = 8'h40;
    localparam logic [7:0] C_COLON  = 8'h3A;
    localparam logic [7:0] C_DOLLAR = 8'h24;
    localparam logic [7:0] C_STAR   = 8'h2A;
    localparam logic [7:0] C_LT     = 8'h3C;
    localparam logic [7:0] C_EQ     = 8'h3D;
    localparam logic [7:0] C_HASH   = 8'h23;
    localparam logic [7:0] C_SPACE  = 8'h20;

    localparam logic [3:0] DEC_MAX = 4'd4;
    localparam logic [3:0] HEX_LEN = 4'd8;

endpackage
`default_nettype wire

// File: rtl/cpu_checker_fsm_char_class.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cpu_checker_fsm_char_class                                  |
// | Brief    : Combinational ASCII classifier (decimal, lowercase hex,     |
// |            space).                                                     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module cpu_checker_fsm_char_class
    import cpu_checker_fsm_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_is_dec,
    output logic       o_is_hex_lc,
    output logic       o_is_space
);

    logic w_is_af;

    assign o_is_dec    = (i_char >= 8'h30) && (i_char <= 8'h39);
    // Uppercase A-F deliberately falls outside the hex class.
    assign w_is_af     = (i_char >= 8'h61) && (i_char <= 8'h66);
    assign o_is_hex_lc = o_is_dec || w_is_af;
    assign o_is_space  = (i_char == C_SPACE);

endmodule
`default_nettype wire

// File: rtl/cpu_checker_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cpu_checker_fsm                                             |
// | Brief    : Character-serial classifier of register/memory write trace  |
// |            records; pulses format_type for one cycle on completion.    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module cpu_checker_fsm
    import cpu_checker_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_is_mem;
    logic       w_is_mem_nxt;

    logic w_is_dec;
    logic w_is_hex;
    logic w_is_space;
    logic w_cnt_inc_ok_dec;
    logic w_cnt_inc_ok_hex;
    logic w_hex_full;

    cpu_checker_fsm_char_class u_char_class (
        .i_char      (char),
        .o_is_dec    (w_is_dec),
        .o_is_hex_lc (w_is_hex),
        .o_is_space  (w_is_space)
    );

    assign w_cnt_inc_ok_dec = (r_cnt < DEC_MAX);
    assign w_cnt_inc_ok_hex = (r_cnt < HEX_LEN);
    assign w_hex_full       = (r_cnt == HEX_LEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_is_mem <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_mem <= w_is_mem_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = 4'd0;
        w_is_mem_nxt = r_is_mem;

        // A caret always resynchronises, whatever the current state.
        if (char == C_CARET) begin
            w_state_nxt = S_TIME;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_TIME: begin
                    if (w_is_dec && w_cnt_inc_ok_dec) begin
                        w_state_nxt = S_TIME;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (char == C_AT && r_cnt != 4'd0) begin
                        w_state_nxt = S_AT_SEEN;
                    end
                end
                S_AT_SEEN: begin
                    if (w_is_hex) begin
                        w_state_nxt = S_PC;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                S_PC: begin
                    if (w_is_hex && w_cnt_inc_ok_hex) begin
                        w_state_nxt = S_PC;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (char == C_COLON && w_hex_full) begin
                        w_state_nxt = S_COLON_SP;
                    end
                end
                S_COLON_SP: begin
                    if (w_is_space) begin
                        w_state_nxt = S_COLON_SP;
                    end else if (char == C_DOLLAR) begin
                        w_state_nxt  = S_REG;
                        w_is_mem_nxt = 1'b0;
                    end else if (char == C_STAR) begin
                        w_state_nxt  = S_MEM;
                        w_is_mem_nxt = 1'b1;
                    end
                end
                S_REG: begin
                    if (w_is_dec && w_cnt_inc_ok_dec) begin
                        w_state_nxt = S_REG;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (r_cnt != 4'd0 && w_is_space) begin
                        w_state_nxt = S_SP_PRE;
                    end else if (r_cnt != 4'd0 && char == C_LT) begin
                        w_state_nxt = S_LT;
                    end
                end
                S_MEM: begin
                    if (w_is_hex && w_cnt_inc_ok_hex) begin
                        w_state_nxt = S_MEM;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_hex_full && w_is_space) begin
                        w_state_nxt = S_SP_PRE;
                    end else if (w_hex_full && char == C_LT) begin
                        w_state_nxt = S_LT;
                    end
                end
                S_SP_PRE: begin
                    if (w_is_space) w_state_nxt = S_SP_PRE;
                    else if (char == C_LT) w_state_nxt = S_LT;
                end
                S_LT: begin
                    if (char == C_EQ) w_state_nxt = S_EQ_SP;
                end
                S_EQ_SP: begin
                    if (w_is_space) begin
                        w_state_nxt = S_EQ_SP;
                    end else if (w_is_hex) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                S_DATA: begin
                    if (w_is_hex && w_cnt_inc_ok_hex) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_hex_full && w_is_space) begin
                        w_state_nxt = S_SP_POST;
                    end else if (w_hex_full && char == C_HASH) begin
                        w_state_nxt = r_is_mem ? S_DONE_MEM : S_DONE_REG;
                    end
                end
                S_SP_POST: begin
                    if (w_is_space) w_state_nxt = S_SP_POST;
                    else if (char == C_HASH) w_state_nxt = r_is_mem ? S_DONE_MEM : S_DONE_REG;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            S_DONE_REG: format_type = FMT_REG;
            S_DONE_MEM: format_type = FMT_MEM;
            default:    format_type = FMT_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_checker_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_cpu_checker_fsm                                          |
// | Brief    : Directed self-checking bench for cpu_checker_fsm.           |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_cpu_checker_fsm;

    logic       clk;
    logic       reset;
    logic [7:0] ch;
    logic [1:0] format_type;

    int n_checks;
    int n_fails;

    cpu_checker_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .char        (ch),
        .format_type (format_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drives a string one char per cycle; only the cycle after the last
    // character may carry a nonzero expected value.
    task automatic send(input string tag, input string s, input logic [1:0] exp, input bit tail);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            @(posedge clk);
            #1;
            check_eq($sformatf("%s[%0d]", tag, i), format_type,
                     (i == s.len() - 1) ? exp : 2'd0);
        end
        if (tail) begin
            @(negedge clk);
            ch = 8'h20;
            @(posedge clk);
            #1;
            check_eq({tag, "_tail"}, format_type, 2'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        ch       = 8'h20;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_val", format_type, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        send("reg_ok",   "^242@000030f4: $31 <= 12345678#", 2'd1, 1'b1);
        send("mem_ok",   "^338@00003130: *00000088 <= ffffb528#", 2'd2, 1'b1);
        send("data6",    "^242@000030f4: $31 <=12321 5#", 2'd0, 1'b1);
        send("data10",   "^242@000030f4: $31 <= 1232158998#", 2'd0, 1'b1);
        send("data0",    "^242@000030f4: $31 <=#", 2'd0, 1'b1);
        send("padding",  "^242@000030f4: $31 <=   ab123215 #", 2'd1, 1'b1);
        send("uc_a",     "^242@000030f4: $31 <= Ab123215#", 2'd0, 1'b1);
        send("uc_b",     "^338@00003130: *00000088 <= Ffffb528#", 2'd0, 1'b1);
        send("uc_c",     "^338@00003130: *00000088 <= ffffB528#", 2'd0, 1'b1);
        send("uc_d",     "^338@00003130: *00000088 <= ffffb52B#", 2'd0, 1'b1);
        send("time5",    "^12345@000030f4: $31 <= 12345678#", 2'd0, 1'b1);
        send("time0",    "^@000030f4: $31 <= 12345678#", 2'd0, 1'b1);
        send("reg0",     "^242@000030f4: $ <= 12345678#", 2'd0, 1'b1);
        send("mem_tight","^7@0000abcd:*0123456a<=deadbeef#", 2'd2, 1'b1);

        // Reset mid-frame: the rest of the aborted frame must not complete.
        send("rst_pre",  "^242@000030f4: $31 <= 1234567", 2'd0, 1'b0);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send("rst_rest", "8#", 2'd0, 1'b1);
        send("rst_ok",   "^242@000030f4: $31 <= 12345678#", 2'd1, 1'b1);

        // Reset while the pulse is high must clear it without a clock edge.
        send("async_pre","^242@000030f4: $31 <= 12345678#", 2'd1, 1'b0);
        #2 reset = 1'b0;
        #1 check_eq("async_rst", format_type, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        send("resync",   "^242@0000^338@00003130: *00000088 <= ffffb528#", 2'd2, 1'b1);

        // Back-to-back frames with no gap.
        send("b2b_a",    "^1@00000000: $1 <= 00000001#", 2'd1, 1'b0);
        send("b2b_b",    "^9999@ffffffff: *00000010 <= 00000002#", 2'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_checker_fsm.md
# cpu_checker_fsm

Character-serial checker for CPU trace lines. One ASCII character is sampled per clock. Each frame is classified as a valid register-write record, a valid memory-write record, or invalid. It sits beside the trace output of the pipeline testbench harness and flags well-formed write records as they complete.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock; `char` is sampled on every edge.
- `reset`  in  1  asynchronous, active-low; 0 forces state to IDLE.
- `char`  in  8  ASCII character presented this cycle.
- `format_type`  out  2  0 = none/invalid, 1 = valid register record, 2 = valid memory record.

## Operation
Accepted grammar (S = zero or more spaces `0x20`):
- Register record: `^` T `@` P `:` S `$` G S `<=` S D S `#`
- Memory record: `^` T `@` P `:` S `*` A S `<=` S D S `#`

Field rules:
- T: 1–4 decimal digits.
- G: 1–4 decimal digits.
- P, A, D: exactly 8 hex digits each.
- Hex digits are `0-9` and lowercase `a-f` only. Uppercase `A-F` is illegal.
- `<=` must be two adjacent characters.

FSM states: IDLE, TIME, AT_SEEN, PC, COLON_SP, REG, MEM, SP_PRE, LT, EQ_SP, DATA, SP_POST, DONE_REG, DONE_MEM.
- Track the active field's digit count with a 4-bit counter.
- Track register vs memory with a 1-bit flag.

Transition rules:
- `^` in any state goes to TIME with the count cleared. This is a resync; the previous frame is discarded.
- A non-digit in TIME or REG after at least one digit continues legally:
  - TIME accepts only `@`.
  - REG accepts space or `<`.
- Any character not allowed by the grammar goes to IDLE. This includes:
  - a 5th decimal digit;
  - a 9th hex digit;
  - fewer than 8 hex digits before the terminator;
  - an empty T or G field;
  - uppercase hex.
- IDLE ignores everything except `^`.
- DATA after 8 digits accepts space (goes to SP_POST) or `#`. `#` goes to DONE_REG or DONE_MEM according to the record-type flag.
- In DONE_* states, the next character `^` goes to TIME; anything else goes to IDLE.

Output:
- `format_type` is a Moore output: 1 in DONE_REG, 2 in DONE_MEM, 0 in every other state.

## Timing
- The `#` is sampled on edge k. `format_type` is valid after edge k and holds for exactly one cycle, until edge k+1.
- Reset value: state IDLE, counter 0, `format_type` = 0.
- Asserting reset mid-frame aborts the frame immediately, without waiting for a clock edge.
- After release, the first legal `^` starts a frame.
- Back-to-back frames are allowed: a `^` immediately following `#` is legal. In that case `format_type` pulses for one cycle and the next frame is parsed with no gap.

## Structure
- Shared package:
  - state enum;
  - `FMT_NONE` / `FMT_REG` / `FMT_MEM` constants;
  - character constants (`^ @ : $ * < = # space`).
- One natural sub-module, `char_class`: a combinational classifier producing `is_dec`, `is_hex_lc` and `is_space` from `char`.
- Top level holds the FSM, the counter and the type flag.

## Test plan
- `^242@000030f4: $31 <= 12345678#` → `format_type` = 1 for one cycle after `#`, 0 otherwise.
- `^338@00003130: *00000088 <= ffffb528#` → 2.
- Data-length errors:
  - `$31 <=12321 5#` (6 digits) → stays 0.
  - `...<= 1232158998#` (10 digits) → stays 0.
  - `...<=#` (empty data) → stays 0.
- Padding: `$31 <=   ab123215 #` (multiple spaces, trailing space) → 1.
- Uppercase hex in the data field → all stay 0:
  - `Ab123215`
  - `Ffffb528`
  - `ffffB528`
  - `ffffb52B`
- Reset asserted low mid-frame, then a full valid register record → no pulse for the aborted frame, then 1.
- `^` injected mid-field restarts parsing; the subsequent complete valid frame → correct pulse.
